// File: rtl/sync_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_arbiter
// Brief    : Round-robin write arbiter with bounded bursts plus read sequencer
//            for a sync FIFO. Optional stall counter: FIFO_ARB_STALL_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module sync_fifo_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DW        = 6,
    parameter int MAX_BURST = 4,
    parameter int RD_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*DW-1:0] req_data,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  fifo_wr_en,
    output logic [DW-1:0]         fifo_dat_in,
    input  logic                  fifo_full,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DW-1:0]         fifo_dat_out,
    input  logic                  cons_ready,
    output logic                  out_valid,
    output logic [DW-1:0]         out_data,
    output logic [7:0]            stall_cnt
);

    localparam int         c_PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_BURST = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [c_PW-1:0] owner_q, owner_d;
    logic [c_PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [3:0]      burst_cnt_q, burst_cnt_d;
    logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;

    logic [c_PW-1:0] w_owner_inc;
    logic [c_PW-1:0] w_base;
    logic [c_PW-1:0] w_win_idx;
    logic            w_win_found;
    logic            w_keep;
    logic [c_PW-1:0] w_grant_idx;
    logic            w_grant_vld;

    assign w_owner_inc = (owner_q == c_PW'(NUM_REQ - 1)) ? '0 : owner_q + c_PW'(1);
    assign w_keep      = (state_q == c_ST_BURST) && req[owner_q] &&
                         (burst_cnt_q < 4'(MAX_BURST));

    // Searching from owner+1 puts the owner last, so it only wins again
    // when no other requester is asserted.
    always_comb begin
        w_base      = (state_q == c_ST_BURST) ? w_owner_inc : rr_ptr_q;
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(w_base) + k) % NUM_REQ]) begin
                w_win_found = 1'b1;
                w_win_idx   = c_PW'((int'(w_base) + k) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= c_ST_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        if (fifo_full) begin
            // Stall freezes the burst; only an owner release is honoured.
            if (state_q == c_ST_BURST && !req[owner_q]) begin
                state_d     = c_ST_IDLE;
                rr_ptr_d    = w_owner_inc;
                burst_cnt_d = '0;
            end
        end else if (w_keep) begin
            burst_cnt_d = burst_cnt_q + 4'd1;
        end else begin
            if (state_q == c_ST_BURST) begin
                rr_ptr_d = w_owner_inc;
            end
            if (w_win_found) begin
                state_d     = c_ST_BURST;
                owner_d     = w_win_idx;
                burst_cnt_d = 4'd1;
            end else begin
                state_d     = c_ST_IDLE;
                burst_cnt_d = '0;
            end
        end
    end

    always_comb begin
        w_grant_idx = w_keep ? owner_q : w_win_idx;
        w_grant_vld = (w_keep | w_win_found) & ~fifo_full & ~rst;
        grant       = '0;
        fifo_dat_in = '0;
        if (w_grant_vld) begin
            grant[w_grant_idx] = 1'b1;
            fifo_dat_in        = req_data[int'(w_grant_idx)*DW +: DW];
        end
        fifo_wr_en = w_grant_vld;
    end

    assign fifo_rd_en = cons_ready & ~fifo_empty & ~rst;

    generate
        if (RD_LAT == 1) begin : g_rd_lat1
            always_comb begin
                rd_pipe_d = fifo_rd_en;
            end
        end else begin : g_rd_latn
            always_comb begin
                rd_pipe_d = {rd_pipe_q[RD_LAT-2:0], fifo_rd_en};
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pipe_q <= '0;
        end else begin
            rd_pipe_q <= rd_pipe_d;
        end
    end

    assign out_valid = rd_pipe_q[RD_LAT-1];
    assign out_data  = out_valid ? fifo_dat_out : '0;

`ifdef FIFO_ARB_STALL_CNT_EN
    logic [7:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((|req) && fifo_full && (stall_cnt_q != 8'hFF)) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 8'h00;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_arbiter
// Brief    : Directed and random checks of sync_fifo_arbiter against a
//            behavioural arbitration / read-pipe model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sync_fifo_arbiter;

    localparam int N      = 4;
    localparam int DW     = 6;
    localparam int MAXB   = 4;
    localparam int RD_LAT = 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    grant;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_dat_in;
    logic            fifo_full = 1'b0;
    logic            fifo_empty = 1'b1;
    logic            fifo_rd_en;
    logic [DW-1:0]   fifo_dat_out = '0;
    logic            cons_ready = 1'b0;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [7:0]      stall_cnt;

    int checks = 0;
    int errors = 0;

    // Model state: current burst owner (-1 = none), grants used, search pointer.
    int         m_owner = -1;
    int         m_used  = 0;
    int         m_ptr   = 0;
    int         m_stall = 0;
    logic [1:0] m_rdh   = '0;

    logic [N-1:0]  o_grant;
    logic          o_rd, o_valid;
    logic [DW-1:0] o_data;
    logic [7:0]    o_stall;

    sync_fifo_arbiter #(.NUM_REQ(N), .DW(DW), .MAX_BURST(MAXB), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .grant(grant),
        .fifo_wr_en(fifo_wr_en), .fifo_dat_in(fifo_dat_in), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_dat_out(fifo_dat_out),
        .cons_ready(cons_ready), .out_valid(out_valid), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_grant();
        int start;
        if (rst || fifo_full) return -1;
        if (m_owner >= 0 && req[m_owner] && m_used < MAXB) return m_owner;
        start = (m_owner >= 0) ? (m_owner + 1) % N : m_ptr;
        for (int k = 0; k < N; k++) begin
            if (req[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    // Called at posedge+1 with inputs applied; checks mid-cycle, then advances.
    task automatic tick();
        int            g;
        logic          e_rd, e_valid;
        logic [N-1:0]  e_grant;
        logic [DW-1:0] e_din;
        logic [7:0]    e_stall;
        #3;
        g       = exp_grant();
        e_grant = (g < 0) ? '0 : (N'(1) << g);
        e_din   = (g < 0) ? '0 : req_data[g*DW +: DW];
        e_rd    = cons_ready & ~fifo_empty & ~rst;
        e_valid = rst ? 1'b0 : m_rdh[RD_LAT-1];
`ifdef FIFO_ARB_STALL_CNT_EN
        e_stall = rst ? 8'h00 : 8'(m_stall);
`else
        e_stall = 8'h00;
`endif
        chk("grant", 32'(grant), 32'(e_grant));
        chk("wr_en", 32'(fifo_wr_en), 32'(g >= 0));
        chk("dat_in", 32'(fifo_dat_in), 32'(e_din));
        chk("rd_en", 32'(fifo_rd_en), 32'(e_rd));
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        chk("out_data", 32'(out_data), e_valid ? 32'(fifo_dat_out) : 32'd0);
        chk("stall_cnt", 32'(stall_cnt), 32'(e_stall));
        o_grant = grant; o_rd = fifo_rd_en; o_valid = out_valid;
        o_data  = out_data; o_stall = stall_cnt;
        @(posedge clk);
        #1;
        if (rst) begin
            m_owner = -1; m_used = 0; m_ptr = 0; m_stall = 0; m_rdh = '0;
        end else begin
            if ((|req) && fifo_full && m_stall < 255) m_stall++;
            m_rdh = {m_rdh[0], e_rd};
            if (fifo_full) begin
                if (m_owner >= 0 && !req[m_owner]) begin
                    m_ptr = (m_owner + 1) % N; m_owner = -1; m_used = 0;
                end
            end else if (g >= 0 && g == m_owner && m_used < MAXB && req[m_owner]) begin
                m_used++;
            end else begin
                if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
                m_owner = g;
                m_used  = (g >= 0) ? 1 : 0;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; fifo_full = 1'b0; fifo_empty = 1'b1; cons_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] dat4 [5];
        logic          rd4  [5];
        logic          v4   [5];
        #1;
        // Reset state with live inputs: everything must read zero.
        rst = 1'b1; req = 4'b1111; req_data = 24'($urandom);
        cons_ready = 1'b1; fifo_empty = 1'b0;
        tick();
        chk("rst_grant", 32'(o_grant), 32'd0);
        chk("rst_rd_en", 32'(o_rd), 32'd0);
        do_reset();

        // Full rotation with all requesters active.
        req = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            req_data = 24'($urandom);
            tick();
            chk("t1_rotation", 32'(o_grant), 32'(1 << ((i / 4) % 4)));
        end

        // Owner drops early, next requester granted in the same cycle.
        do_reset();
        req = 4'b0101;
        tick(); chk("t2_g0a", 32'(o_grant), 32'h1);
        tick(); chk("t2_g0b", 32'(o_grant), 32'h1);
        req = 4'b0100;
        tick(); chk("t2_g2", 32'(o_grant), 32'h4);

        // Full stall inside requester 2's burst does not consume it.
        do_reset();
        req = 4'b0100;
        tick(); tick();
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(); chk("t3_stall", 32'(o_grant), 32'h0);
        end
        fifo_full = 1'b0;
        tick(); chk("t3_resume_a", 32'(o_grant), 32'h4);
        tick(); chk("t3_resume_b", 32'(o_grant), 32'h4);
`ifdef FIFO_ARB_STALL_CNT_EN
        chk("t3_stall_cnt", 32'(o_stall), 32'd5);
`else
        chk("t3_stall_cnt", 32'(o_stall), 32'd0);
`endif

        // Three-word read with one-cycle latency.
        do_reset();
        dat4 = '{6'h00, 6'h15, 6'h2A, 6'h3F, 6'h00};
        rd4  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        v4   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        cons_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fifo_empty   = (i >= 3);
            fifo_dat_out = dat4[i];
            tick();
            chk("t4_rd_en", 32'(o_rd), 32'(rd4[i]));
            chk("t4_valid", 32'(o_valid), 32'(v4[i]));
            chk("t4_data", 32'(o_data), v4[i] ? 32'(dat4[i]) : 32'd0);
        end
        cons_ready = 1'b0;

        // Asynchronous reset mid-burst with a read in flight.
        do_reset();
        req = 4'b1111; fifo_dat_out = 6'h2B;
        tick(); tick();
        cons_ready = 1'b1; fifo_empty = 1'b0;
        tick();
        cons_ready = 1'b0; fifo_empty = 1'b1;
        #1;
        chk("t5_valid_pre", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_async_grant", 32'(grant), 32'd0);
        chk("t5_async_wr", 32'(fifo_wr_en), 32'd0);
        chk("t5_async_din", 32'(fifo_dat_in), 32'd0);
        chk("t5_async_valid", 32'(out_valid), 32'd0);
        chk("t5_async_data", 32'(out_data), 32'd0);
        tick();
        rst = 1'b0; req = 4'b1010;
        tick(); chk("t5_first_grant", 32'(o_grant), 32'h2);

        // Long full stall: counter saturates (or stays 0 without the feature).
        do_reset();
        req = 4'b0011; fifo_full = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        tick();
`ifdef FIFO_ARB_STALL_CNT_EN
        chk("t6_sat", 32'(o_stall), 32'hFF);
`else
        chk("t6_sat", 32'(o_stall), 32'h00);
`endif
        fifo_full = 1'b0;

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            req          = N'($urandom);
            req_data     = 24'($urandom);
            fifo_full    = ($urandom_range(0, 3) == 0);
            fifo_empty   = ($urandom_range(0, 3) == 0);
            cons_ready   = 1'($urandom);
            fifo_dat_out = DW'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
